// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: formats word-wide data-memory bus requests, extends load data,
// stalls the pipeline while the memory is busy, and flags misaligned accesses and bus timeouts.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResult_in,
  input  logic [31:0] MemWriteData_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  Load_in,
  input  logic [1:0]  Store_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] LoadData_o,
  output logic        Mem_Stall,
  output logic        Misalign_o,
  output logic        BusErr_o
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;
  typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] cnt_inc;

  // Load formatting is captured at issue so the extension does not depend on EX/MEM later.
  logic       is_load_q;
  size_e      ld_size_q;
  logic       ld_signed_q;
  logic [1:0] off_q;

  logic        access;
  size_e       size;
  logic        sgn;
  logic [1:0]  off;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  logic        issue;
  logic        finish_ack;
  logic        finish_to;

  logic [31:0] shifted;
  logic [31:0] ext;
  logic [31:0] load_result;

  assign access = MemRead_in | MemWrite_in;
  assign off    = ALUResult_in[1:0];

  // Access decode; a simultaneous read and write is treated as a read.
  always_comb begin
    size = SzWord;
    sgn  = 1'b0;
    if (MemRead_in) begin
      case (Load_in)
        3'd1: begin size = SzHalf; sgn = 1'b1; end
        3'd2: size = SzHalf;
        3'd3: begin size = SzByte; sgn = 1'b1; end
        3'd4: size = SzByte;
        default: size = SzWord;
      endcase
    end else begin
      case (Store_in)
        2'd1: size = SzHalf;
        2'd2: size = SzByte;
        default: size = SzWord;
      endcase
    end
  end

  always_comb begin
    misaligned = 1'b0;
    be_calc    = 4'b1111;
    wdata_calc = MemWriteData_in;
    case (size)
      SzByte: begin
        be_calc    = 4'b0001 << off;
        wdata_calc = {4{MemWriteData_in[7:0]}};
      end
      SzHalf: begin
        misaligned = off[0];
        be_calc    = 4'b0011 << off;
        wdata_calc = {2{MemWriteData_in[15:0]}};
      end
      default: begin
        misaligned = (off != 2'b00);
      end
    endcase
  end

  // Read-data extraction for the lane captured at issue.
  always_comb begin
    shifted = dmem_rdata >> {off_q, 3'b000};
    case (ld_size_q)
      SzByte:  ext = {{24{ld_signed_q & shifted[7]}}, shifted[7:0]};
      SzHalf:  ext = {{16{ld_signed_q & shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
    load_result = is_load_q ? ext : 32'h0;
  end

  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    Mem_Stall  = 1'b0;
    Misalign_o = 1'b0;
    issue      = 1'b0;
    finish_ack = 1'b0;
    finish_to  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (access) begin
          if (misaligned) begin
            Misalign_o = 1'b1;
          end else begin
            Mem_Stall = 1'b1;
            issue     = 1'b1;
            cnt_d     = 8'd0;
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        Mem_Stall = 1'b1;
        cnt_d     = cnt_inc;
        // An ack arriving on the timeout cycle still completes the access normally.
        if (dmem_ack) begin
          finish_ack = 1'b1;
          state_d    = StDone;
        end else if (cnt_inc == TimeoutCnt) begin
          finish_to = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 8'd0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_be     <= 4'h0;
      dmem_wdata  <= 32'h0;
      LoadData_o  <= 32'h0;
      BusErr_o    <= 1'b0;
      is_load_q   <= 1'b0;
      ld_size_q   <= SzWord;
      ld_signed_q <= 1'b0;
      off_q       <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      BusErr_o <= finish_to;
      if (issue) begin
        dmem_req    <= 1'b1;
        dmem_we     <= ~MemRead_in;
        dmem_addr   <= {ALUResult_in[31:2], 2'b00};
        dmem_be     <= be_calc;
        dmem_wdata  <= wdata_calc;
        is_load_q   <= MemRead_in;
        ld_size_q   <= size;
        ld_signed_q <= sgn;
        off_q       <= off;
      end
      if (finish_ack || finish_to) begin
        dmem_req <= 1'b0;
        dmem_we  <= 1'b0;
        dmem_be  <= 4'h0;
      end
      if (finish_ack) begin
        LoadData_o <= load_result;
      end else if (finish_to || Misalign_o) begin
        LoadData_o <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table-driven bench for mem_access_unit plus hand-written timeout and reset sequences.
module tb_mem_access_unit;

  localparam int unsigned TO = 6;

  logic        clk;
  logic        rst;
  logic [31:0] alu;
  logic [31:0] wd;
  logic        mrd;
  logic        mwr;
  logic [2:0]  ld;
  logic [1:0]  st;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic [31:0] load_data;
  logic        mem_stall;
  logic        misalign;
  logic        bus_err;

  int n_cmp = 0;
  int n_fail = 0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .ALUResult_in    (alu),
    .MemWriteData_in (wd),
    .MemRead_in      (mrd),
    .MemWrite_in     (mwr),
    .Load_in         (ld),
    .Store_in        (st),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_be         (dmem_be),
    .dmem_wdata      (dmem_wdata),
    .dmem_rdata      (dmem_rdata),
    .dmem_ack        (dmem_ack),
    .LoadData_o      (load_data),
    .Mem_Stall       (mem_stall),
    .Misalign_o      (misalign),
    .BusErr_o        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          wait_n;
    logic        mis;
    logic        we;
    logic [3:0]  be;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic [31:0] eload;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    mrd = 1'b0; mwr = 1'b0; ld = 3'd0; st = 2'd0; alu = 32'h0; wd = 32'h0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(posedge clk); #1;
    mrd = v.rd; mwr = v.wr; ld = v.ld; st = v.st; alu = v.addr; wd = v.wd; dmem_ack = 1'b0;
    #1;
    check($sformatf("v%0d idle_stall", idx), 32'(mem_stall), 32'(!v.mis));
    check($sformatf("v%0d idle_misalign", idx), 32'(misalign), 32'(v.mis));
    check($sformatf("v%0d idle_req", idx), 32'(dmem_req), 32'd0);
    if (v.mis) begin
      @(posedge clk); #1;
      clear_inputs();
      #1;
      check($sformatf("v%0d mis_req", idx), 32'(dmem_req), 32'd0);
      check($sformatf("v%0d mis_pulse_end", idx), 32'(misalign), 32'd0);
      check($sformatf("v%0d mis_load", idx), load_data, 32'h0);
    end else begin
      for (int i = 1; i <= v.wait_n; i++) begin
        @(posedge clk); #1;
        check($sformatf("v%0d w%0d req", idx, i), 32'(dmem_req), 32'd1);
        check($sformatf("v%0d w%0d stall", idx, i), 32'(mem_stall), 32'd1);
        check($sformatf("v%0d w%0d we", idx, i), 32'(dmem_we), 32'(v.we));
        check($sformatf("v%0d w%0d be", idx, i), 32'(dmem_be), 32'(v.be));
        check($sformatf("v%0d w%0d addr", idx, i), dmem_addr, v.eaddr);
        check($sformatf("v%0d w%0d wdata", idx, i), dmem_wdata, v.ewd);
        if (i == v.wait_n) begin
          dmem_ack = 1'b1;
          dmem_rdata = v.rdata;
        end
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      dmem_rdata = 32'h0;
      clear_inputs();
      #1;
      check($sformatf("v%0d done_req", idx), 32'(dmem_req), 32'd0);
      check($sformatf("v%0d done_stall", idx), 32'(mem_stall), 32'd0);
      check($sformatf("v%0d done_load", idx), load_data, v.eload);
      check($sformatf("v%0d done_buserr", idx), 32'(bus_err), 32'd0);
    end
  endtask

  initial begin
    int waits;
    //          rd    wr    ld    st    addr          wd            rdata         n  mis   we    be     eaddr         ewd           eload
    vecs[0]  = '{1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 2, 1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF};
    vecs[1]  = '{1'b1, 1'b0, 3'd3, 2'd0, 32'h0000_0103, 32'h0,        32'h8012_3456, 1, 1'b0, 1'b0, 4'h8, 32'h0000_0100, 32'h0,        32'hFFFF_FF80};
    vecs[2]  = '{1'b1, 1'b0, 3'd4, 2'd0, 32'h0000_0103, 32'h0,        32'h8012_3456, 1, 1'b0, 1'b0, 4'h8, 32'h0000_0100, 32'h0,        32'h0000_0080};
    vecs[3]  = '{1'b1, 1'b0, 3'd0, 2'd0, 32'h0000_0101, 32'h0,        32'h0,         0, 1'b1, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0};
    vecs[4]  = '{1'b0, 1'b1, 3'd0, 2'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1, 1'b0, 1'b1, 4'hC, 32'h0000_0200, 32'hABCD_ABCD, 32'h0};
    vecs[5]  = '{1'b1, 1'b0, 3'd1, 2'd0, 32'h0000_0102, 32'h0,        32'h8001_1234, 1, 1'b0, 1'b0, 4'hC, 32'h0000_0100, 32'h0,        32'hFFFF_8001};
    vecs[6]  = '{1'b1, 1'b0, 3'd2, 2'd0, 32'h0000_0100, 32'h0,        32'h8001_F234, 2, 1'b0, 1'b0, 4'h3, 32'h0000_0100, 32'h0,        32'h0000_F234};
    vecs[7]  = '{1'b0, 1'b1, 3'd0, 2'd2, 32'h0000_0101, 32'h0000_00A5, 32'h0,        1, 1'b0, 1'b1, 4'h2, 32'h0000_0100, 32'hA5A5_A5A5, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, 3'd0, 2'd0, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,        3, 1'b0, 1'b1, 4'hF, 32'h0000_0204, 32'hCAFE_F00D, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 3'd4, 2'd0, 32'h0000_0302, 32'h0,        32'h00AB_0000, 1, 1'b0, 1'b0, 4'h4, 32'h0000_0300, 32'h0,        32'h0000_00AB};
    vecs[10] = '{1'b0, 1'b1, 3'd0, 2'd1, 32'h0000_0203, 32'h1111_2222, 32'h0,        0, 1'b1, 1'b0, 4'h0, 32'h0,         32'h0,        32'h0};
    vecs[11] = '{1'b1, 1'b0, 3'd3, 2'd0, 32'h0000_0001, 32'h0,        32'h0000_7F00, 1, 1'b0, 1'b0, 4'h2, 32'h0000_0000, 32'h0,        32'h0000_007F};
    vecs[12] = '{1'b1, 1'b0, 3'd7, 2'd0, 32'h0000_0010, 32'h0,        32'h1122_3344, 1, 1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0,        32'h1122_3344};
    vecs[13] = '{1'b0, 1'b1, 3'd0, 2'd3, 32'h0000_0020, 32'h55AA_55AA, 32'h0,        1, 1'b0, 1'b1, 4'hF, 32'h0000_0020, 32'h55AA_55AA, 32'h0};

    rst = 1'b1;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check("rst req", 32'(dmem_req), 32'd0);
    check("rst we", 32'(dmem_we), 32'd0);
    check("rst addr", dmem_addr, 32'h0);
    check("rst be", 32'(dmem_be), 32'd0);
    check("rst wdata", dmem_wdata, 32'h0);
    check("rst load", load_data, 32'h0);
    check("rst stall", 32'(mem_stall), 32'd0);
    check("rst misalign", 32'(misalign), 32'd0);
    check("rst buserr", 32'(bus_err), 32'd0);
    rst = 1'b0;

    // Ack while idle must be ignored.
    @(posedge clk); #1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("stray_ack req", 32'(dmem_req), 32'd0);
    check("stray_ack load", load_data, 32'h0);
    check("stray_ack buserr", 32'(bus_err), 32'd0);

    for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

    // Store timeout: req must stay up for exactly TO WAIT cycles.
    @(posedge clk); #1;
    mwr = 1'b1; st = 2'd0; alu = 32'h0000_0040; wd = 32'h0BAD_F00D;
    waits = 0;
    for (int i = 0; i < int'(TO) + 5; i++) begin
      @(posedge clk); #1;
      if (dmem_req) waits++;
      else break;
    end
    clear_inputs();
    #1;
    check("to wait_cycles", 32'(waits), 32'(TO));
    check("to buserr", 32'(bus_err), 32'd1);
    check("to stall", 32'(mem_stall), 32'd0);
    check("to load", load_data, 32'h0);
    @(posedge clk); #1;
    check("to buserr_pulse_end", 32'(bus_err), 32'd0);

    // Ack exactly on the timeout cycle wins over the timeout.
    @(posedge clk); #1;
    mrd = 1'b1; ld = 3'd0; alu = 32'h0000_0044;
    for (int i = 1; i <= int'(TO); i++) begin
      @(posedge clk); #1;
      if (i == int'(TO)) begin
        dmem_ack = 1'b1;
        dmem_rdata = 32'h1357_9BDF;
      end
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    clear_inputs();
    #1;
    check("to_ack buserr", 32'(bus_err), 32'd0);
    check("to_ack load", load_data, 32'h1357_9BDF);
    check("to_ack req", 32'(dmem_req), 32'd0);

    // Reset during the second WAIT cycle abandons the access.
    @(posedge clk); #1;
    mrd = 1'b1; ld = 3'd0; alu = 32'h0000_0080;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstw req_before", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    #1;
    check("rstw req", 32'(dmem_req), 32'd0);
    check("rstw stall", 32'(mem_stall), 32'd0);
    check("rstw load", load_data, 32'h0);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hAAAA_5555;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("rstw late_ack load", load_data, 32'h0);
    check("rstw late_ack req", 32'(dmem_req), 32'd0);
    check("rstw late_ack buserr", 32'(bus_err), 32'd0);
    @(posedge clk); #1;
    check("rstw late_ack stall", 32'(mem_stall), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
